// File: rtl/execute_m_stage_param_if.sv
// rtl/execute_m_stage_param_if.sv - E-stage operand bundle in, registered M-stage bundle out
interface execute_m_stage_param_if #(
   parameter int DATA_W = 64,
   parameter int PC_W   = 64,
   parameter int REG_W  = 4,
   parameter int STAT_W = 3
);
   logic [STAT_W-1:0] E_stat;
   logic [PC_W-1:0]   E_pc;
   logic [3:0]        E_icode;
   logic [3:0]        E_ifunc;
   logic [DATA_W-1:0] E_valA;
   logic [DATA_W-1:0] E_valB;
   logic [DATA_W-1:0] E_valC;
   logic [REG_W-1:0]  E_dstE;
   logic [REG_W-1:0]  E_dstM;

   logic [STAT_W-1:0] M_stat;
   logic [PC_W-1:0]   M_pc;
   logic [3:0]        M_icode;
   logic [3:0]        M_ifunc;
   logic              M_Cnd;
   logic [DATA_W-1:0] M_valE;
   logic [DATA_W-1:0] M_valA;
   logic [REG_W-1:0]  M_dstE;
   logic [REG_W-1:0]  M_dstM;

   modport master (
      output E_stat, E_pc, E_icode, E_ifunc, E_valA, E_valB, E_valC, E_dstE, E_dstM,
      input  M_stat, M_pc, M_icode, M_ifunc, M_Cnd, M_valE, M_valA, M_dstE, M_dstM
   );

   modport slave (
      input  E_stat, E_pc, E_icode, E_ifunc, E_valA, E_valB, E_valC, E_dstE, E_dstM,
      output M_stat, M_pc, M_icode, M_ifunc, M_Cnd, M_valE, M_valA, M_dstE, M_dstM
   );
endinterface

// File: rtl/execute_m_stage_param.sv
// rtl/execute_m_stage_param.sv - Y86 execute stage with fused E->M register and condition codes
// Define MUL_EN to add a shift-add mulq (OPq ifunc 4); otherwise ifunc 4-15 raise INS.
module execute_m_stage_param #(
   parameter int DATA_W     = 64,
   parameter int PC_W       = 64,
   parameter int REG_W      = 4,
   parameter int STAT_W     = 3,
   parameter int WORD_BYTES = 8
) (
   input  logic                clk_i,
   input  logic                rst_i,
   execute_m_stage_param_if.slave bus_io,
   input  logic [STAT_W-1:0]   m_stat_i,
   input  logic [STAT_W-1:0]   W_stat_i,
   input  logic                M_stall_i,
   input  logic                M_bubble_i,
   output logic [DATA_W-1:0]   e_valE_o,
   output logic [REG_W-1:0]    e_dstE_o,
   output logic                e_Cnd_o,
   output logic                e_busy_o,
   output logic [2:0]          cc_o
);
   localparam int MSB = DATA_W - 1;
   localparam logic [STAT_W-1:0] S_AOK = STAT_W'(1);
   localparam logic [STAT_W-1:0] S_INS = STAT_W'(4);
   localparam logic [REG_W-1:0]  RNONE = '1;
   localparam logic [DATA_W-1:0] WORD  = DATA_W'(WORD_BYTES);
   localparam logic [3:0] I_NOP = 4'h1, I_RRMOV = 4'h2, I_IRMOV = 4'h3, I_RMMOV = 4'h4;
   localparam logic [3:0] I_MRMOV = 4'h5, I_OPQ = 4'h6, I_CALL = 4'h8, I_RET = 4'h9;
   localparam logic [3:0] I_PUSH = 4'hA, I_POP = 4'hB;

   typedef struct packed {
      logic [STAT_W-1:0] stat;
      logic [PC_W-1:0]   pc;
      logic [3:0]        icode;
      logic [3:0]        ifunc;
      logic              cnd;
      logic [DATA_W-1:0] valE;
      logic [DATA_W-1:0] valA;
      logic [REG_W-1:0]  dstE;
      logic [REG_W-1:0]  dstM;
   } m_reg_t;

   logic [3:0]        icode, ifunc;
   logic [DATA_W-1:0] alu_a, alu_b, res;
   logic              res_of, is_op, op_bad, cc_upd;
   logic [2:0]        cc_q, cc_d;
   m_reg_t            m_q, m_d;

   assign icode = bus_io.E_icode;
   assign ifunc = bus_io.E_ifunc;
   assign is_op = (icode == I_OPQ);

`ifdef MUL_EN
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} mul_state_t;
   localparam int CNT_W = $clog2(DATA_W);

   mul_state_t        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic              mul_done;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
      end
   end

   // Operands are read straight from E inputs, which upstream holds while busy.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      e_busy_o = 1'b0;
      mul_done = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (is_op && ifunc == 4'h4 && bus_io.E_stat == S_AOK) begin
               state_d  = ST_RUN;
               e_busy_o = 1'b1;
               cnt_d    = '0;
               acc_d    = '0;
            end
         end
         ST_RUN: begin
            e_busy_o = 1'b1;
            acc_d    = acc_q + (bus_io.E_valA[cnt_q] ? (bus_io.E_valB << cnt_q) : '0);
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(DATA_W - 1)) state_d = ST_DONE;
         end
         ST_DONE: begin
            mul_done = 1'b1;
            if (!M_stall_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end
`else
   assign e_busy_o = 1'b0;
`endif

   always_comb begin
      alu_a = '0;
      alu_b = '0;
      case (icode)
         I_RRMOV, I_OPQ:          alu_a = bus_io.E_valA;
         I_IRMOV, I_RMMOV, I_MRMOV: alu_a = bus_io.E_valC;
         I_CALL, I_PUSH:          alu_a = '0 - WORD;
         I_RET, I_POP:            alu_a = WORD;
         default:                 alu_a = '0;
      endcase
      case (icode)
         I_RMMOV, I_MRMOV, I_OPQ, I_CALL, I_RET, I_PUSH, I_POP: alu_b = bus_io.E_valB;
         default: alu_b = '0;
      endcase
   end

   always_comb begin
      res    = alu_b + alu_a;
      res_of = 1'b0;
      op_bad = 1'b0;
      if (is_op) begin
         case (ifunc)
            4'h0: res_of = (alu_a[MSB] == alu_b[MSB]) && (res[MSB] != alu_a[MSB]);
            4'h1: begin
               res    = alu_b - alu_a;
               res_of = (alu_b[MSB] != alu_a[MSB]) && (res[MSB] != alu_b[MSB]);
            end
            4'h2: res = alu_b & alu_a;
            4'h3: res = alu_b ^ alu_a;
`ifdef MUL_EN
            4'h4: res = mul_done ? acc_q : '0;
`endif
            default: begin
               res    = '0;
               op_bad = 1'b1;
            end
         endcase
      end
   end

   assign e_valE_o = res;

   // CC only moves for a real ALU op while nothing older in the pipe has faulted.
   assign cc_upd = is_op && !op_bad && !e_busy_o && (bus_io.E_stat == S_AOK) &&
                   (m_stat_i == S_AOK) && (W_stat_i == S_AOK);
   assign cc_d   = cc_upd ? {(res == '0), res[MSB], res_of} : cc_q;
   assign cc_o   = cc_q;

   always_comb begin
      case (ifunc)
         4'h0:    e_Cnd_o = 1'b1;
         4'h1:    e_Cnd_o = (cc_q[1] ^ cc_q[0]) | cc_q[2];
         4'h2:    e_Cnd_o = cc_q[1] ^ cc_q[0];
         4'h3:    e_Cnd_o = cc_q[2];
         4'h4:    e_Cnd_o = ~cc_q[2];
         4'h5:    e_Cnd_o = ~(cc_q[1] ^ cc_q[0]);
         4'h6:    e_Cnd_o = ~(cc_q[1] ^ cc_q[0]) & ~cc_q[2];
         default: e_Cnd_o = 1'b0;
      endcase
   end

   assign e_dstE_o = (icode == I_RRMOV && !e_Cnd_o) ? RNONE : bus_io.E_dstE;

   always_comb begin
      m_d = m_q;
      if (M_bubble_i || (!M_stall_i && e_busy_o)) begin
         m_d.stat  = S_AOK;
         m_d.pc    = '0;
         m_d.icode = I_NOP;
         m_d.ifunc = '0;
         m_d.cnd   = 1'b0;
         m_d.valE  = '0;
         m_d.valA  = '0;
         m_d.dstE  = RNONE;
         m_d.dstM  = RNONE;
      end else if (!M_stall_i) begin
         m_d.stat  = (is_op && op_bad) ? S_INS : bus_io.E_stat;
         m_d.pc    = bus_io.E_pc;
         m_d.icode = icode;
         m_d.ifunc = ifunc;
         m_d.cnd   = e_Cnd_o;
         m_d.valE  = e_valE_o;
         m_d.valA  = bus_io.E_valA;
         m_d.dstE  = e_dstE_o;
         m_d.dstM  = bus_io.E_dstM;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cc_q    <= 3'b100;
         m_q     <= '0;
         m_q.stat  <= S_AOK;
         m_q.icode <= I_NOP;
         m_q.dstE  <= RNONE;
         m_q.dstM  <= RNONE;
      end else begin
         cc_q <= cc_d;
         m_q  <= m_d;
      end
   end

   assign bus_io.M_stat  = m_q.stat;
   assign bus_io.M_pc    = m_q.pc;
   assign bus_io.M_icode = m_q.icode;
   assign bus_io.M_ifunc = m_q.ifunc;
   assign bus_io.M_Cnd   = m_q.cnd;
   assign bus_io.M_valE  = m_q.valE;
   assign bus_io.M_valA  = m_q.valA;
   assign bus_io.M_dstE  = m_q.dstE;
   assign bus_io.M_dstM  = m_q.dstM;
endmodule

// File: tb/tb_execute_m_stage_param.sv
// tb/tb_execute_m_stage_param.sv - directed vector table plus randomized model check of execute_m_stage_param
module tb_execute_m_stage_param;
   localparam logic [2:0] AOK = 3'd1, HLT = 3'd2, ADR = 3'd3, INS = 3'd4;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  m_stat, w_stat;
   logic        m_stall, m_bubble;
   logic [63:0] e_valE;
   logic [3:0]  e_dstE;
   logic        e_Cnd, e_busy;
   logic [2:0]  cc;

   always #5 clk = ~clk;

   execute_m_stage_param_if #(.DATA_W(64), .PC_W(64), .REG_W(4), .STAT_W(3)) bus_if ();

   execute_m_stage_param #(.DATA_W(64), .PC_W(64), .REG_W(4), .STAT_W(3), .WORD_BYTES(8)) dut (
      .clk_i(clk), .rst_i(rst), .bus_io(bus_if.slave),
      .m_stat_i(m_stat), .W_stat_i(w_stat), .M_stall_i(m_stall), .M_bubble_i(m_bubble),
      .e_valE_o(e_valE), .e_dstE_o(e_dstE), .e_Cnd_o(e_Cnd), .e_busy_o(e_busy), .cc_o(cc)
   );

   typedef struct {
      logic rst, stall, bubble;
      logic [2:0] mst;
      logic [3:0] icode, ifunc;
      logic [63:0] a, b, c;
      logic [3:0] dste;
      logic [63:0] x_vale;
      logic x_cnd;
      logic [3:0] x_dste;
      logic [2:0] x_mst;
      logic [3:0] x_icode;
      logic [63:0] x_mvale;
      logic [3:0] x_mdste;
      logic [2:0] x_cc;
   } vec_t;

   typedef struct {
      logic [2:0] stat;
      logic [63:0] pc;
      logic [3:0] icode, ifunc;
      logic cnd;
      logic [63:0] vale, vala;
      logic [3:0] dste, dstm;
   } mreg_t;

   int n_tests = 0;
   int n_fail  = 0;
   vec_t  vecs[16];
   mreg_t mm;
   logic [2:0] cc_m;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, st, bu, input logic [2:0] es, ms, ws,
                        input logic [3:0] ic, fn, input logic [63:0] pc, a, b, c,
                        input logic [3:0] de, dm);
      rst = r; m_stall = st; m_bubble = bu; m_stat = ms; w_stat = ws;
      bus_if.E_stat = es; bus_if.E_pc = pc; bus_if.E_icode = ic; bus_if.E_ifunc = fn;
      bus_if.E_valA = a; bus_if.E_valB = b; bus_if.E_valC = c;
      bus_if.E_dstE = de; bus_if.E_dstM = dm;
   endtask

   function automatic mreg_t f_bubble();
      mreg_t r;
      r = '{stat: AOK, pc: 64'd0, icode: 4'h1, ifunc: 4'h0, cnd: 1'b0,
            vale: 64'd0, vala: 64'd0, dste: 4'hF, dstm: 4'hF};
      return r;
   endfunction

   function automatic logic [63:0] f_opq(input logic [3:0] fn, input logic [63:0] a, b);
      case (fn)
         4'h0: return b + a;
         4'h1: return b - a;
         4'h2: return b & a;
         4'h3: return b ^ a;
         default: return 64'd0;
      endcase
   endfunction

   function automatic logic [63:0] f_vale(input logic [3:0] ic, fn, input logic [63:0] a, b, c);
      case (ic)
         4'h2: return a;
         4'h3: return c;
         4'h4, 4'h5: return b + c;
         4'h6: return f_opq(fn, a, b);
         4'h8, 4'hA: return b - 64'd8;
         4'h9, 4'hB: return b + 64'd8;
         default: return 64'd0;
      endcase
   endfunction

   // Signed overflow: the exact 65-bit result does not fit back into 64 bits.
   function automatic logic f_of(input logic [3:0] fn, input logic [63:0] a, b);
      logic signed [64:0] w;
      if (fn == 4'h0) w = $signed({b[63], b}) + $signed({a[63], a});
      else if (fn == 4'h1) w = $signed({b[63], b}) - $signed({a[63], a});
      else return 1'b0;
      return w[64] != w[63];
   endfunction

   function automatic logic f_cnd(input logic [3:0] fn, input logic [2:0] c);
      logic zf, sf, of;
      {zf, sf, of} = c;
      case (fn)
         4'h0: return 1'b1;
         4'h1: return (sf != of) || zf;
         4'h2: return sf != of;
         4'h3: return zf;
         4'h4: return !zf;
         4'h5: return sf == of;
         4'h6: return (sf == of) && !zf;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [2:0] f_stat();
      if ($urandom_range(0, 7) != 0) return AOK;
      return 3'($urandom_range(2, 4));
   endfunction

   task automatic chk_m(input string p, input mreg_t x, input logic [2:0] xcc);
      chk({p, " M_stat"},  64'(bus_if.M_stat),  64'(x.stat));
      chk({p, " M_pc"},    bus_if.M_pc,         x.pc);
      chk({p, " M_icode"}, 64'(bus_if.M_icode), 64'(x.icode));
      chk({p, " M_ifunc"}, 64'(bus_if.M_ifunc), 64'(x.ifunc));
      chk({p, " M_Cnd"},   64'(bus_if.M_Cnd),   64'(x.cnd));
      chk({p, " M_valE"},  bus_if.M_valE,       x.vale);
      chk({p, " M_valA"},  bus_if.M_valA,       x.vala);
      chk({p, " M_dstE"},  64'(bus_if.M_dstE),  64'(x.dste));
      chk({p, " M_dstM"},  64'(bus_if.M_dstM),  64'(x.dstm));
      chk({p, " cc"},      64'(cc),             64'(xcc));
   endtask

   logic [3:0]  r_ic, r_fn, r_de, r_dm;
   logic [63:0] r_a, r_b, r_c, r_pc, x_vale;
   logic [2:0]  r_es, r_ms, r_ws;
   logic        r_rst, r_st, r_bu, x_cnd;
   logic [3:0]  x_dste;
   int          n_busy;

   initial begin
      vecs[0]  = '{0,0,0,AOK,4'h3,4'h0,64'd0,64'd0,64'd100,4'h2, 64'd100,1,4'h2, AOK,4'h3,64'd100,4'h2,3'b100};
      vecs[1]  = '{0,0,0,AOK,4'h6,4'h0,64'd1,64'd1,64'd0,4'h4, 64'd2,1,4'h4, AOK,4'h6,64'd2,4'h4,3'b000};
      vecs[2]  = '{0,0,0,AOK,4'h6,4'h1,64'd5,64'd5,64'd0,4'h4, 64'd0,0,4'h4, AOK,4'h6,64'd0,4'h4,3'b100};
      vecs[3]  = '{0,0,0,AOK,4'h2,4'h1,64'h55,64'd0,64'd0,4'h3, 64'h55,1,4'h3, AOK,4'h2,64'h55,4'h3,3'b100};
      vecs[4]  = '{0,0,0,AOK,4'h2,4'h2,64'h66,64'd0,64'd0,4'h3, 64'h66,0,4'hF, AOK,4'h2,64'h66,4'hF,3'b100};
      vecs[5]  = '{0,0,0,AOK,4'h6,4'h0,64'h7FFF_FFFF_FFFF_FFFF,64'd1,64'd0,4'h5,
                   64'h8000_0000_0000_0000,1,4'h5, AOK,4'h6,64'h8000_0000_0000_0000,4'h5,3'b011};
      vecs[6]  = '{0,0,0,ADR,4'h6,4'h0,64'h7FFF_FFFF_FFFF_FFFF,64'd1,64'd0,4'h5,
                   64'h8000_0000_0000_0000,1,4'h5, AOK,4'h6,64'h8000_0000_0000_0000,4'h5,3'b011};
      vecs[7]  = '{0,0,0,AOK,4'h6,4'h7,64'd3,64'd4,64'd0,4'h5, 64'd0,0,4'h5, INS,4'h6,64'd0,4'h5,3'b011};
      vecs[8]  = '{0,0,0,AOK,4'hA,4'h0,64'd0,64'h100,64'd0,4'h4, 64'hF8,1,4'h4, AOK,4'hA,64'hF8,4'h4,3'b011};
      vecs[9]  = '{0,0,0,AOK,4'hB,4'h0,64'd0,64'h100,64'd0,4'h4, 64'h108,1,4'h4, AOK,4'hB,64'h108,4'h4,3'b011};
      vecs[10] = '{0,1,0,AOK,4'h3,4'h0,64'd0,64'd0,64'd9,4'h2, 64'd9,1,4'h2, AOK,4'hB,64'h108,4'h4,3'b011};
      vecs[11] = '{0,1,0,AOK,4'h3,4'h0,64'd0,64'd0,64'd9,4'h2, 64'd9,1,4'h2, AOK,4'hB,64'h108,4'h4,3'b011};
      vecs[12] = '{0,1,1,AOK,4'h3,4'h0,64'd0,64'd0,64'd9,4'h2, 64'd9,1,4'h2, AOK,4'h1,64'd0,4'hF,3'b011};
      vecs[13] = '{0,0,0,AOK,4'h6,4'h1,64'd5,64'd3,64'd0,4'h6,
                   64'hFFFF_FFFF_FFFF_FFFE,0,4'h6, AOK,4'h6,64'hFFFF_FFFF_FFFF_FFFE,4'h6,3'b010};
      vecs[14] = '{1,0,0,AOK,4'h3,4'h0,64'd0,64'd0,64'd9,4'h2, 64'd9,1,4'h2, AOK,4'h1,64'd0,4'hF,3'b100};
      vecs[15] = '{0,0,0,AOK,4'h3,4'h0,64'd0,64'd0,64'd9,4'h2, 64'd9,1,4'h2, AOK,4'h3,64'd9,4'h2,3'b100};

      drive(1, 0, 0, AOK, AOK, AOK, 4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
      repeat (2) @(posedge clk);
      #1;
      chk_m("reset", f_bubble(), 3'b100);
      chk("reset e_busy", 64'(e_busy), 64'd0);

      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         drive(vecs[i].rst, vecs[i].stall, vecs[i].bubble, AOK, vecs[i].mst, AOK,
               vecs[i].icode, vecs[i].ifunc, 64'd0, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].dste, 4'hF);
         #1;
         chk($sformatf("v%0d e_valE", i), e_valE, vecs[i].x_vale);
         chk($sformatf("v%0d e_Cnd", i), 64'(e_Cnd), 64'(vecs[i].x_cnd));
         chk($sformatf("v%0d e_dstE", i), 64'(e_dstE), 64'(vecs[i].x_dste));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d M_stat", i), 64'(bus_if.M_stat), 64'(vecs[i].x_mst));
         chk($sformatf("v%0d M_icode", i), 64'(bus_if.M_icode), 64'(vecs[i].x_icode));
         chk($sformatf("v%0d M_valE", i), bus_if.M_valE, vecs[i].x_mvale);
         chk($sformatf("v%0d M_dstE", i), 64'(bus_if.M_dstE), 64'(vecs[i].x_mdste));
         chk($sformatf("v%0d cc", i), 64'(cc), 64'(vecs[i].x_cc));
      end

      @(negedge clk);
      drive(1, 0, 0, AOK, AOK, AOK, 4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
      @(posedge clk);
      mm   = f_bubble();
      cc_m = 3'b100;

      for (int i = 0; i < 400; i++) begin
         r_ic = 4'($urandom_range(0, 11));
         r_fn = 4'($urandom_range(0, 15));
         if (r_ic == 4'h6) r_fn = 4'($urandom_range(0, 5));
`ifdef MUL_EN
         if (r_ic == 4'h6 && r_fn == 4'h4) r_fn = 4'h5;
`endif
         r_a  = {$urandom, $urandom};
         r_b  = ($urandom_range(0, 3) == 0) ? r_a : {$urandom, $urandom};
         r_c  = {$urandom, $urandom};
         r_pc = {$urandom, $urandom};
         r_de = 4'($urandom_range(0, 15));
         r_dm = 4'($urandom_range(0, 15));
         r_es = f_stat(); r_ms = f_stat(); r_ws = f_stat();
         r_rst = ($urandom_range(0, 49) == 0);
         r_st  = ($urandom_range(0, 5) == 0);
         r_bu  = ($urandom_range(0, 7) == 0);
         @(negedge clk);
         drive(r_rst, r_st, r_bu, r_es, r_ms, r_ws, r_ic, r_fn, r_pc, r_a, r_b, r_c, r_de, r_dm);
         #1;
         x_vale = f_vale(r_ic, r_fn, r_a, r_b, r_c);
         x_cnd  = f_cnd(r_fn, cc_m);
         x_dste = (r_ic == 4'h2 && !x_cnd) ? 4'hF : r_de;
         chk("rnd e_valE", e_valE, x_vale);
         chk("rnd e_Cnd", 64'(e_Cnd), 64'(x_cnd));
         chk("rnd e_dstE", 64'(e_dstE), 64'(x_dste));
         chk("rnd e_busy", 64'(e_busy), 64'd0);
         if (r_rst) begin
            mm   = f_bubble();
            cc_m = 3'b100;
         end else begin
            if (r_ic == 4'h6 && r_fn < 4 && r_es == AOK && r_ms == AOK && r_ws == AOK)
               cc_m = {x_vale == 64'd0, x_vale[63], f_of(r_fn, r_a, r_b)};
            if (r_bu) mm = f_bubble();
            else if (!r_st)
               mm = '{stat: (r_ic == 4'h6 && r_fn >= 4) ? INS : r_es, pc: r_pc, icode: r_ic,
                      ifunc: r_fn, cnd: x_cnd, vale: x_vale, vala: r_a, dste: x_dste, dstm: r_dm};
         end
         @(posedge clk);
         #1;
         chk_m("rnd", mm, cc_m);
      end

`ifdef MUL_EN
      @(negedge clk);
      drive(1, 0, 0, AOK, AOK, AOK, 4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
      @(negedge clk);
      drive(0, 0, 0, AOK, AOK, AOK, 4'h6, 4'h4, 64'd0, 64'd7, 64'd6, 64'd0, 4'h1, 4'hF);
      n_busy = 0;
      while (e_busy && n_busy < 200) begin
         @(posedge clk);
         @(negedge clk);
         n_busy++;
      end
      chk("mul busy cycles", 64'(n_busy), 64'd65);
      chk("mul e_valE", e_valE, 64'd42);
      @(posedge clk);
      #1;
      chk("mul M_valE", bus_if.M_valE, 64'd42);
      chk("mul cc", 64'(cc), 64'd0);
      repeat (11) @(posedge clk);
      @(negedge clk);
      chk("mul busy mid-run", 64'(e_busy), 64'd1);
      drive(1, 0, 0, AOK, AOK, AOK, 4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
      @(posedge clk);
      #1;
      chk("mul rst busy", 64'(e_busy), 64'd0);
      chk("mul rst M_icode", 64'(bus_if.M_icode), 64'd1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
